// File: rtl/eth_send_arp.sv
// ARP frame transmitter: emits one Ethernet II ARP reply (optionally a request when
// ETH_SEND_ARP_REQ_EN is defined) as a 72-byte stream, followed by an idle inter-frame gap.
module eth_send_arp #(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_02,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
`ifdef ETH_SEND_ARP_REQ_EN
  input  logic        i_req,
`endif
  input  logic [47:0] i_tha,
  input  logic [31:0] i_tpa,
  output logic        o_busy,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_done,
  output logic [7:0]  o_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DST_MAC, S_SRC_MAC, S_TYPE, S_ARP_HDR,
    S_SHA, S_SPA, S_THA, S_TPA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [7:0]      IFG_LAST  = 8'(IFG_BYTES - 1);
  localparam logic [5:0][7:0] MAC_B     = LOCAL_MAC;
  localparam logic [3:0][7:0] IP_B      = LOCAL_IP;
  localparam logic [7:0][7:0] ARP_HDR_B = {8'h00, 8'h01, 8'h08, 8'h00,
                                           8'h06, 8'h04, 8'h00, 8'h02};

  state_t          state, nxt_state;
  logic [7:0]      cnt, nxt_cnt, last_cnt;
  logic [7:0]      nxt_byte;
  logic            nxt_vl;
  logic [47:0]     tha_q;
  logic [31:0]     tpa_q;
  logic            req_q;
  logic [31:0]     crc, crc_next, crc_cur;
  logic            crc_en, accept;
  logic [5:0][7:0] tha_b;
  logic [3:0][7:0] tpa_b;
  logic [3:0][7:0] fcs_b;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign accept   = (state == S_IDLE) && i_start;
  assign tha_b    = tha_q;
  assign tpa_b    = tpa_q;
  assign o_state  = {4'h0, state};

  // The CRC folds in the byte currently on the wire, so crc_cur already covers the
  // last PAD byte when the first FCS byte is chosen.
  assign crc_en   = (state >= S_DST_MAC) && (state <= S_PAD);
  assign crc_next = crc32_byte(crc, o_data);
  assign crc_cur  = crc_en ? crc_next : crc;
  assign fcs_b    = ~crc_cur;

  always_comb begin
    last_cnt = 8'd0;
    case (state)
      S_PREAMBLE: last_cnt = 8'd6;
      S_SFD:      last_cnt = 8'd0;
      S_DST_MAC,
      S_SRC_MAC,
      S_SHA,
      S_THA:      last_cnt = 8'd5;
      S_TYPE:     last_cnt = 8'd1;
      S_ARP_HDR:  last_cnt = 8'd7;
      S_SPA,
      S_TPA,
      S_FCS:      last_cnt = 8'd3;
      S_PAD:      last_cnt = 8'd17;
      S_IFG:      last_cnt = IFG_LAST;
      default:    last_cnt = 8'd0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 8'd1;
    if (state == S_IDLE) begin
      nxt_cnt = 8'd0;
      if (i_start) nxt_state = S_PREAMBLE;
    end else if (cnt == last_cnt) begin
      nxt_cnt   = 8'd0;
      nxt_state = (state == S_IFG) ? S_IDLE : state_t'(state + 4'd1);
    end
  end

  // Byte for the position the FSM moves to; registered so outputs change on the edge.
  always_comb begin
    nxt_byte = 8'h00;
    nxt_vl   = 1'b1;
    case (nxt_state)
      S_PREAMBLE: nxt_byte = 8'h55;
      S_SFD:      nxt_byte = 8'hD5;
      S_DST_MAC:  nxt_byte = req_q ? 8'hFF : tha_b[3'd5 - nxt_cnt[2:0]];
      S_SRC_MAC:  nxt_byte = MAC_B[3'd5 - nxt_cnt[2:0]];
      S_TYPE:     nxt_byte = nxt_cnt[0] ? 8'h06 : 8'h08;
      S_ARP_HDR:  nxt_byte = (req_q && nxt_cnt[2:0] == 3'd7) ? 8'h01
                                                             : ARP_HDR_B[3'd7 - nxt_cnt[2:0]];
      S_SHA:      nxt_byte = MAC_B[3'd5 - nxt_cnt[2:0]];
      S_SPA:      nxt_byte = IP_B[2'd3 - nxt_cnt[1:0]];
      S_THA:      nxt_byte = req_q ? 8'h00 : tha_b[3'd5 - nxt_cnt[2:0]];
      S_TPA:      nxt_byte = tpa_b[2'd3 - nxt_cnt[1:0]];
      S_PAD:      nxt_byte = 8'h00;
      S_FCS:      nxt_byte = fcs_b[nxt_cnt[1:0]];
      default:    nxt_vl   = 1'b0;
    endcase
  end

`ifndef ETH_SEND_ARP_REQ_EN
  assign req_q = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      crc       <= 32'hFFFF_FFFF;
      tha_q     <= 48'h0;
      tpa_q     <= 32'h0;
`ifdef ETH_SEND_ARP_REQ_EN
      req_q     <= 1'b0;
`endif
      o_data    <= 8'h00;
      o_data_vl <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      o_data    <= nxt_byte;
      o_data_vl <= nxt_vl;
      o_busy    <= (nxt_state != S_IDLE);
      o_done    <= (nxt_state == S_IFG) && (nxt_cnt == IFG_LAST);
      if (accept) begin
        tha_q <= i_tha;
        tpa_q <= i_tpa;
`ifdef ETH_SEND_ARP_REQ_EN
        req_q <= i_req;
`endif
        crc   <= 32'hFFFF_FFFF;
      end else if (crc_en) begin
        crc <= crc_next;
      end
    end
  end

endmodule

// File: tb/tb_eth_send_arp.sv
// Directed bench for eth_send_arp: reset, frame contents, input latching, back-to-back,
// mid-frame reset and (with ETH_SEND_ARP_REQ_EN) the request variant.
module tb_eth_send_arp;

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP  = 32'hC0_A8_01_02;
  localparam int          IFG = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
`ifdef ETH_SEND_ARP_REQ_EN
  logic        i_req = 1'b0;
`endif
  logic [47:0] i_tha = 48'h0;
  logic [31:0] i_tpa = 32'h0;
  logic        o_busy, o_data_vl, o_done;
  logic [7:0]  o_data, o_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_b [72];
  logic [7:0] got_b [72];

  always #5 clk = ~clk;

  eth_send_arp #(.LOCAL_MAC(MAC), .LOCAL_IP(IP), .IFG_BYTES(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
`ifdef ETH_SEND_ARP_REQ_EN
    .i_req(i_req),
`endif
    .i_tha(i_tha), .i_tpa(i_tpa), .o_busy(o_busy), .o_data(o_data),
    .o_data_vl(o_data_vl), .o_done(o_done), .o_state(o_state)
  );

  // Expected wire image, built field by field with a bitwise CRC-32 reference.
  task automatic build_exp(input logic [47:0] tha, input logic [31:0] tpa, input bit req);
    logic [47:0] mac;
    logic [31:0] ip;
    logic [31:0] crc;
    mac = MAC;
    ip  = IP;
    for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
    exp_b[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      exp_b[8+i]  = req ? 8'hFF : tha[47-8*i -: 8];
      exp_b[14+i] = mac[47-8*i -: 8];
      exp_b[30+i] = mac[47-8*i -: 8];
      exp_b[40+i] = req ? 8'h00 : tha[47-8*i -: 8];
    end
    exp_b[20] = 8'h08; exp_b[21] = 8'h06;
    exp_b[22] = 8'h00; exp_b[23] = 8'h01; exp_b[24] = 8'h08; exp_b[25] = 8'h00;
    exp_b[26] = 8'h06; exp_b[27] = 8'h04; exp_b[28] = 8'h00;
    exp_b[29] = req ? 8'h01 : 8'h02;
    for (int i = 0; i < 4; i++) begin
      exp_b[36+i] = ip[31-8*i -: 8];
      exp_b[46+i] = tpa[31-8*i -: 8];
    end
    for (int i = 0; i < 18; i++) exp_b[50+i] = 8'h00;
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) begin
      crc = crc ^ {24'h0, exp_b[i]};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_b[68+i] = crc[8*i +: 8];
  endtask

  // Waits (bounded) for o_data_vl, then records 72 bytes; returns at the first IFG cycle.
  task automatic capture_frame(output bit ok, output bit vl_ok, output bit busy_ok);
    int n;
    n = 0; ok = 1'b0; vl_ok = 1'b1; busy_ok = 1'b1;
    while (o_data_vl !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (o_data_vl !== 1'b1) return;
    ok = 1'b1;
    for (int i = 0; i < 72; i++) begin
      got_b[i] = o_data;
      if (o_data_vl !== 1'b1) vl_ok = 1'b0;
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (o_done !== 1'b1 && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    if (o_done !== 1'b1) lat = -1;
  endtask

  task automatic pulse_start;
    @(negedge clk) i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({o_data, o_data_vl, o_busy, o_done, o_state} !== 19'h0) begin
      errors++;
      $display("FAIL reset_hold got data=%h vl=%b busy=%b done=%b state=%h want all 0",
               o_data, o_data_vl, o_busy, o_done, o_state);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({o_data, o_data_vl, o_busy, o_done, o_state} !== 19'h0) begin
        errors++;
        $display("FAIL idle_cycle%0d got data=%h vl=%b busy=%b done=%b state=%h want all 0",
                 c, o_data, o_data_vl, o_busy, o_done, o_state);
      end
    end
  endtask

  task automatic test_frame;
    bit ok, vl_ok, busy_ok;
    int lat;
    i_tha = 48'h00_11_22_33_44_55;
    i_tpa = 32'hC0_A8_01_01;
    build_exp(i_tha, i_tpa, 1'b0);
    pulse_start();
    capture_frame(ok, vl_ok, busy_ok);
    checks++;
    if (!ok || !vl_ok || !busy_ok) begin
      errors++;
      $display("FAIL t2_stream got ok=%b vl_cont=%b busy=%b want 1 1 1", ok, vl_ok, busy_ok);
    end
    checks++;
    if (o_data_vl !== 1'b0) begin
      errors++;
      $display("FAIL t2_after_fcs got vl=%b want 0", o_data_vl);
    end
    if (ok) begin
      for (int i = 0; i < 72; i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL t2_byte%0d got %h want %h", i, got_b[i], exp_b[i]);
        end
      end
    end
    wait_done(lat);
    checks++;
    if (lat != IFG - 1) begin
      errors++;
      $display("FAIL t2_done_latency got %0d want %0d", lat, IFG - 1);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_state !== 8'd0) begin
      errors++;
      $display("FAIL t2_post_done got busy=%b done=%b state=%h want 0 0 00", o_busy, o_done, o_state);
    end
  endtask

  task automatic test_latch;
    bit ok, vl_ok, busy_ok;
    int lat;
    @(negedge clk);
    i_tha = 48'hA1_B2_C3_D4_E5_F6;
    i_tpa = 32'h0A_00_00_07;
    build_exp(i_tha, i_tpa, 1'b0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_tha = {16'($urandom()), $urandom()};
    i_tpa = $urandom();
    capture_frame(ok, vl_ok, busy_ok);
    checks++;
    if (!ok || !vl_ok) begin
      errors++;
      $display("FAIL t4_stream got ok=%b vl_cont=%b want 1 1", ok, vl_ok);
    end
    if (ok) begin
      for (int i = 0; i < 72; i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL t4_byte%0d got %h want %h", i, got_b[i], exp_b[i]);
        end
      end
    end
    wait_done(lat);
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int lat, extra;
    pulse_start();
    repeat (20) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk) i_start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL ignore_done got timeout want o_done");
    end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_data_vl === 1'b1 || o_busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_requeue got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    bit ok, vl_ok, busy_ok;
    int gap, dones, lat;
    i_tha = 48'h12_34_56_78_9A_BC;
    i_tpa = 32'hC0_A8_01_0A;
    build_exp(i_tha, i_tpa, 1'b0);
    @(negedge clk) i_start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      capture_frame(ok, vl_ok, busy_ok);
      checks++;
      if (!ok || !vl_ok) begin
        errors++;
        $display("FAIL t3_stream%0d got ok=%b vl_cont=%b want 1 1", f, ok, vl_ok);
      end
      if (ok) begin
        for (int i = 0; i < 72; i++) begin
          checks++;
          if (got_b[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL t3_f%0d_byte%0d got %h want %h", f, i, got_b[i], exp_b[i]);
          end
        end
      end
      if (f == 0) begin
        gap = 0; dones = 0;
        while (o_data_vl !== 1'b1 && gap < 600) begin
          if (o_done === 1'b1) dones++;
          @(negedge clk);
          gap++;
        end
        i_start = 1'b0;
        checks++;
        if (gap != IFG + 1) begin
          errors++;
          $display("FAIL t3_gap got %0d idle cycles want %0d", gap, IFG + 1);
        end
        checks++;
        if (dones != 1) begin
          errors++;
          $display("FAIL t3_done_count got %0d want 1", dones);
        end
      end
    end
    wait_done(lat);
    checks++;
    if (lat != IFG - 1) begin
      errors++;
      $display("FAIL t3_done_latency got %0d want %0d", lat, IFG - 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok, vl_ok, busy_ok;
    int n, lat, dones;
    i_tha = 48'h66_77_88_99_AA_BB;
    i_tpa = 32'hC0_A8_01_05;
    build_exp(i_tha, i_tpa, 1'b0);
    pulse_start();
    n = 0;
    while (o_data_vl !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    checks++;
    if (o_data !== exp_b[30] || o_state !== 8'd7) begin
      errors++;
      $display("FAIL t5_byte30 got data=%h state=%h want %h 07", o_data, o_state, exp_b[30]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data, o_data_vl, o_busy, o_done, o_state} !== 19'h0) begin
      errors++;
      $display("FAIL t5_async_reset got data=%h vl=%b busy=%b state=%h want all 0",
               o_data, o_data_vl, o_busy, o_state);
    end
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_data_vl === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL t5_no_done got %0d activity cycles want 0", dones);
    end
    i_tha = 48'h0A_0B_0C_0D_0E_0F;
    i_tpa = 32'hC0_A8_01_06;
    build_exp(i_tha, i_tpa, 1'b0);
    pulse_start();
    capture_frame(ok, vl_ok, busy_ok);
    checks++;
    if (!ok || !vl_ok) begin
      errors++;
      $display("FAIL t5_stream got ok=%b vl_cont=%b want 1 1", ok, vl_ok);
    end
    if (ok) begin
      for (int i = 0; i < 72; i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL t5_byte%0d got %h want %h", i, got_b[i], exp_b[i]);
        end
      end
    end
    wait_done(lat);
    checks++;
    if (lat != IFG - 1) begin
      errors++;
      $display("FAIL t5_done_latency got %0d want %0d", lat, IFG - 1);
    end
    @(negedge clk);
  endtask

`ifdef ETH_SEND_ARP_REQ_EN
  task automatic test_req;
    bit ok, vl_ok, busy_ok;
    int lat;
    i_tha = 48'h00_11_22_33_44_55;
    i_tpa = 32'hC0_A8_01_64;
    build_exp(i_tha, i_tpa, 1'b1);
    @(negedge clk) begin i_start = 1'b1; i_req = 1'b1; end
    @(negedge clk) begin i_start = 1'b0; i_req = 1'b0; end
    capture_frame(ok, vl_ok, busy_ok);
    checks++;
    if (!ok || !vl_ok) begin
      errors++;
      $display("FAIL t6_stream got ok=%b vl_cont=%b want 1 1", ok, vl_ok);
    end
    if (ok) begin
      for (int i = 0; i < 72; i++) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL t6_byte%0d got %h want %h", i, got_b[i], exp_b[i]);
        end
      end
    end
    wait_done(lat);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_latch();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef ETH_SEND_ARP_REQ_EN
    test_req();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
